// File: rtl/serial_pack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_pack_pkg
// Purpose  : Shared definitions for the serial word packer: default widths,
//            the packer FSM state encoding and a width helper.
// Revision : 1.0 - initial release
// ============================================================================
package serial_pack_pkg;

   // Default word width and frame-counter width
   localparam int WORD_W_DEF = 8;
   localparam int CNT_W_DEF  = 8;

   // Packer FSM states, explicit 2-bit encoding
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      COLLECT = 2'd2
   } pack_state_t;

   // Width needed to hold a bit count in the range 0..word_w
   function automatic int nbits_width(input int word_w);
      return $clog2(word_w) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/word_hold_reg.sv
`default_nettype none
// ============================================================================
// Module   : word_hold_reg
// Purpose  : 1-deep valid/ready holding register for packed words. Accepts a
//            push when empty or when the current word leaves in the same
//            cycle; otherwise drops the word and raises a sticky overflow.
// Revision : 1.0 - initial release
// ============================================================================
module word_hold_reg
   import serial_pack_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF,
   parameter int NB_W   = nbits_width(WORD_W_DEF)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [WORD_W-1:0] push_word,
   input  logic [NB_W-1:0]   push_nbits,
   input  logic              push_last,
   input  logic              pop_ready,
   output logic              accepted,
   output logic [WORD_W-1:0] word_out,
   output logic [NB_W-1:0]   word_nbits,
   output logic              word_last,
   output logic              word_valid,
   output logic              overflow
);

   logic              r_valid;
   logic [WORD_W-1:0] r_word;
   logic [NB_W-1:0]   r_nbits;
   logic              r_last;
   logic              r_overflow;

   logic              w_pop;
   logic              w_accept;

   // The slot is free for a new word if empty or being drained this cycle
   always_comb begin
      w_pop    = r_valid & pop_ready;
      w_accept = push & (~r_valid | pop_ready);
   end

   // Holding register: load on accept, clear valid on a bare pop, flag drops
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_word     <= '0;
         r_nbits    <= '0;
         r_last     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_accept) begin
            r_valid <= 1'b1;
            r_word  <= push_word;
            r_nbits <= push_nbits;
            r_last  <= push_last;
         end else if (w_pop) begin
            r_valid <= 1'b0;
         end
         if (push && !w_accept) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign accepted   = w_accept;
   assign word_out   = r_word;
   assign word_nbits = r_nbits;
   assign word_last  = r_last;
   assign word_valid = r_valid;
   assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: rtl/serial_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_packer
// Purpose  : Packs the gated serial stream (qualified by ser_en, framed by
//            wake) MSB-first into WORD_W-bit words, emits partial frame-final
//            words, counts words per frame and pulses frame_done at frame end.
// Revision : 1.0 - initial release
// ============================================================================
module serial_word_packer
   import serial_pack_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ser_in,
   input  logic                   ser_en,
   input  logic                   wake,
   output logic [WORD_W-1:0]      word_out,
   output logic                   word_valid,
   input  logic                   word_ready,
   output logic                   word_last,
   output logic [$clog2(WORD_W):0] word_nbits,
   output logic [CNT_W-1:0]       frame_words,
   output logic                   frame_done,
   output logic                   overflow
);

   localparam int c_nb_w = $clog2(WORD_W) + 1;
   localparam int c_bc_w = $clog2(WORD_W);
   localparam logic [c_bc_w-1:0] c_last_cnt = c_bc_w'(WORD_W - 1);
   localparam logic [c_nb_w-1:0] c_full_nb  = c_nb_w'(WORD_W);

   pack_state_t       r_state;
   pack_state_t       w_state_nxt;

   logic [WORD_W-1:0] r_sr;
   logic [c_bc_w-1:0] r_cnt;
   logic              r_wake_q;
   logic              r_frame_done;
   logic [CNT_W-1:0]  r_frame_words;

   logic              w_wake_rise;
   logic [WORD_W-1:0] w_full_word;
   logic [c_nb_w-1:0] w_shamt;
   logic [WORD_W-1:0] w_partial_word;

   logic              w_shift;
   logic [c_bc_w-1:0] w_cnt_nxt;
   logic              w_push;
   logic [WORD_W-1:0] w_push_word;
   logic [c_nb_w-1:0] w_push_nbits;
   logic              w_push_last;
   logic              w_frame_end;
   logic              w_frame_clr;
   logic              w_accepted;

   // Derived datapath values: edge detect, completed word, left-aligned partial
   always_comb begin
      w_wake_rise    = wake & ~r_wake_q;
      w_full_word    = {r_sr[WORD_W-2:0], ser_in};
      w_shamt        = c_full_nb - {1'b0, r_cnt};
      // Stale bits above the valid count fall off the top of the shift
      w_partial_word = r_sr << w_shamt;
   end

   // FSM next state plus control strobes for the datapath and holding register
   always_comb begin
      w_state_nxt  = r_state;
      w_shift      = 1'b0;
      w_cnt_nxt    = r_cnt;
      w_push       = 1'b0;
      w_push_word  = '0;
      w_push_nbits = '0;
      w_push_last  = 1'b0;
      w_frame_end  = 1'b0;
      w_frame_clr  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_wake_rise) begin
               w_state_nxt = ARMED;
               w_cnt_nxt   = '0;
               w_frame_clr = 1'b1;
            end
         end
         ARMED: begin
            if (!wake) begin
               w_state_nxt = IDLE;
            end else if (ser_en) begin
               w_shift     = 1'b1;
               w_cnt_nxt   = c_bc_w'(1);
               w_state_nxt = COLLECT;
            end
         end
         COLLECT: begin
            if (!wake) begin
               // Abort: partial bits are discarded silently
               w_cnt_nxt   = '0;
               w_state_nxt = IDLE;
            end else if (ser_en) begin
               w_shift = 1'b1;
               if (r_cnt == c_last_cnt) begin
                  w_push       = 1'b1;
                  w_push_word  = w_full_word;
                  w_push_nbits = c_full_nb;
                  w_cnt_nxt    = '0;
               end else begin
                  w_cnt_nxt = r_cnt + c_bc_w'(1);
               end
            end else begin
               if (r_cnt != '0) begin
                  w_push       = 1'b1;
                  w_push_word  = w_partial_word;
                  w_push_nbits = {1'b0, r_cnt};
                  w_push_last  = 1'b1;
               end
               w_cnt_nxt   = '0;
               w_frame_end = 1'b1;
               w_state_nxt = ARMED;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Shift register, bit counter, wake history and frame-end pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sr         <= '0;
         r_cnt        <= '0;
         r_wake_q     <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_wake_q     <= wake;
         r_cnt        <= w_cnt_nxt;
         r_frame_done <= w_frame_end;
         if (w_shift) begin
            r_sr <= w_full_word;
         end
      end
   end

   // Per-frame count of words that made it into the holding register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_words <= '0;
      end else if (w_frame_clr) begin
         r_frame_words <= '0;
      end else if (w_accepted && (r_frame_words != {CNT_W{1'b1}})) begin
         r_frame_words <= r_frame_words + CNT_W'(1);
      end
   end

   word_hold_reg #(
      .WORD_W (WORD_W),
      .NB_W   (c_nb_w)
   ) u_hold (
      .clk        (clk),
      .rst        (rst),
      .push       (w_push),
      .push_word  (w_push_word),
      .push_nbits (w_push_nbits),
      .push_last  (w_push_last),
      .pop_ready  (word_ready),
      .accepted   (w_accepted),
      .word_out   (word_out),
      .word_nbits (word_nbits),
      .word_last  (word_last),
      .word_valid (word_valid),
      .overflow   (overflow)
   );

   assign frame_words = r_frame_words;
   assign frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_word_packer
// Purpose  : Self-checking bench for serial_word_packer (WORD_W=8). A
//            queue-based reference model tracks frames as bit lists and a
//            scoreboard checks every presented word and status output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_word_packer;

   localparam int WORD_W = 8;
   localparam int CNT_W  = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              ser_in;
   logic              ser_en;
   logic              wake;
   logic              word_ready;
   logic [WORD_W-1:0] word_out;
   logic              word_valid;
   logic              word_last;
   logic [3:0]        word_nbits;
   logic [CNT_W-1:0]  frame_words;
   logic              frame_done;
   logic              overflow;

   typedef struct {
      logic [7:0] w;
      int         nb;
      bit         last;
   } exp_t;

   exp_t exp_q[$];

   // reference model state
   bit   m_open, m_coll, m_wake_q, m_valid, m_ovf, m_done;
   int   m_fw;
   bit   bits[$];

   // checker state (written only by the monitor)
   int         checks = 0;
   int         failures = 0;
   int         done_probe = 0;
   logic [7:0] pop_w0 = '0, pop_w1 = '0;
   logic [3:0] pop_nb = '0;
   logic       pop_last = 1'b0;

   // request from the stimulus process for a directed check
   int         probe_id = 0;

   always #25 clk = ~clk;

   serial_word_packer #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .ser_in      (ser_in),
      .ser_en      (ser_en),
      .wake        (wake),
      .word_out    (word_out),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .word_last   (word_last),
      .word_nbits  (word_nbits),
      .frame_words (frame_words),
      .frame_done  (frame_done),
      .overflow    (overflow)
   );

   function automatic exp_t make_word(input bit b[$], input bit is_last);
      exp_t e;
      int   v = 0;
      foreach (b[i]) v = v * 2 + int'(b[i]);
      v = v * (1 << (WORD_W - b.size()));
      e.w    = v[7:0];
      e.nb   = b.size();
      e.last = is_last;
      return e;
   endfunction

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // reference model: frames as bit lists, holding register as a flag
   initial begin : ref_model
      bit   push, done;
      exp_t e;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_open = 0; m_coll = 0; m_wake_q = 0; m_valid = 0;
            m_ovf = 0; m_done = 0; m_fw = 0;
            bits.delete();
            exp_q.delete();
         end else begin
            push = 0;
            done = 0;
            e = '{w: 8'h00, nb: 0, last: 1'b0};
            if (!m_open) begin
               if (wake && !m_wake_q) begin
                  m_open = 1; m_coll = 0; m_fw = 0;
                  bits.delete();
               end
            end else if (!wake) begin
               m_open = 0; m_coll = 0;
               bits.delete();
            end else if (ser_en) begin
               bits.push_back(ser_in);
               m_coll = 1;
               if (bits.size() == WORD_W) begin
                  e = make_word(bits, 1'b0);
                  push = 1;
                  bits.delete();
               end
            end else if (m_coll) begin
               if (bits.size() > 0) begin
                  e = make_word(bits, 1'b1);
                  push = 1;
               end
               bits.delete();
               done = 1;
               m_coll = 0;
            end
            if (push) begin
               if (!m_valid || word_ready) begin
                  m_valid = 1;
                  exp_q.push_back(e);
                  if (m_fw < (1 << CNT_W) - 1) m_fw++;
               end else begin
                  m_ovf = 1;
               end
            end else if (m_valid && word_ready) begin
               m_valid = 0;
            end
            m_done   = done;
            m_wake_q = wake;
         end
      end
   end

   // monitor: compare DUT against the model half a cycle after each edge
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         chk("word_valid", 32'(word_valid), 32'(m_valid));
         chk("frame_done", 32'(frame_done), 32'(m_done));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         chk("frame_words", 32'(frame_words), 32'(m_fw));
         if (word_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 32'(word_out), 32'hFFFF_FFFF);
            end else begin
               e = exp_q[0];
               chk("word_out", 32'(word_out), 32'(e.w));
               chk("word_nbits", 32'(word_nbits), 32'(e.nb));
               chk("word_last", 32'(word_last), 32'(e.last));
               if (word_ready) begin
                  void'(exp_q.pop_front());
                  pop_w0   = pop_w1;
                  pop_w1   = word_out;
                  pop_nb   = word_nbits;
                  pop_last = word_last;
               end
            end
         end
         if (probe_id != done_probe) begin
            done_probe = probe_id;
            case (probe_id)
               1: begin
                  chk("rst_word_out", 32'(word_out), 32'h0);
                  chk("rst_word_nbits", 32'(word_nbits), 32'h0);
                  chk("rst_word_last", 32'(word_last), 32'h0);
                  chk("rst_frame_words", 32'(frame_words), 32'h0);
               end
               2: begin
                  chk("t2_word", 32'(pop_w1), 32'hB2);
                  chk("t2_nbits", 32'(pop_nb), 32'd8);
                  chk("t2_last", 32'(pop_last), 32'd0);
                  chk("t2_frame_words", 32'(frame_words), 32'd1);
               end
               3: begin
                  chk("t3_full_word", 32'(pop_w0), 32'hF0);
                  chk("t3_partial_word", 32'(pop_w1), 32'hA0);
                  chk("t3_partial_nbits", 32'(pop_nb), 32'd3);
                  chk("t3_partial_last", 32'(pop_last), 32'd1);
                  chk("t3_frame_words", 32'(frame_words), 32'd2);
               end
               4: begin
                  chk("t4_valid_held", 32'(word_valid), 32'd1);
                  chk("t4_word_held", 32'(word_out), 32'h5A);
                  chk("t4_overflow", 32'(overflow), 32'd1);
                  chk("t4_frame_words", 32'(frame_words), 32'd1);
               end
               5: begin
                  chk("t4_valid_cleared", 32'(word_valid), 32'd0);
                  chk("t4_overflow_sticky", 32'(overflow), 32'd1);
                  chk("t4_word_kept", 32'(word_out), 32'h5A);
               end
               6: begin
                  chk("t5_word", 32'(pop_w1), 32'h3C);
                  chk("t5_nbits", 32'(pop_nb), 32'd8);
                  chk("t5_frame_words", 32'(frame_words), 32'd1);
               end
               7: begin
                  chk("t6_valid", 32'(word_valid), 32'd0);
                  chk("t6_overflow", 32'(overflow), 32'd0);
                  chk("t6_frame_words", 32'(frame_words), 32'd0);
               end
               8: begin
                  chk("end_scoreboard_empty", 32'(exp_q.size()), 32'd0);
                  chk("end_valid", 32'(word_valid), 32'd0);
               end
               default: ;
            endcase
         end
      end
   end

   task automatic cyc(input bit r, input bit w, input bit e, input bit d, input bit rdy);
      @(posedge clk);
      #1;
      rst = r; wake = w; ser_en = e; ser_in = d; word_ready = rdy;
   endtask

   task automatic probe(input int id);
      @(posedge clk);
      #1;
      probe_id = id;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit rdy);
      for (int i = 7; i >= 0; i--) cyc(0, 1, 1, b[i], rdy);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stimulus
      bit       w_r;
      bit [2:0] b3;
      rst = 1'b1;
      wake = 1'($urandom);
      ser_en = 1'($urandom);
      ser_in = 1'($urandom);
      word_ready = 1'($urandom);
      probe(1);
      // test 1: idle with random serial activity, no frame open
      for (int i = 0; i < 6; i++) cyc(0, 0, 1'($urandom), 1'($urandom), 1'($urandom));

      // test 2: single full word 8'hB2, then frame end
      cyc(0, 1, 0, 0, 1);
      send_byte(8'hB2, 1);
      cyc(0, 1, 0, 0, 1);
      probe(2);

      // test 3: 11 bits -> full word then 3-bit partial
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 1, 0, 0, 1);
      send_byte(8'hF0, 1);
      b3 = 3'b101;
      for (int i = 2; i >= 0; i--) cyc(0, 1, 1, b3[i], 1);
      cyc(0, 1, 0, 0, 1);
      probe(3);

      // test 4: consumer stalled, second word dropped
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 1, 0, 0, 0);
      send_byte(8'h5A, 0);
      send_byte(8'hC3, 0);
      cyc(0, 1, 0, 0, 0);
      probe(4);
      cyc(0, 1, 0, 0, 1);
      probe(5);

      // test 5: aborted frame, then clean 8'h3C
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 1, 0, 0, 1);
      for (int i = 0; i < 5; i++) cyc(0, 1, 1, 1'($urandom), 1);
      cyc(0, 0, 1, 1, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 1, 0, 0, 1);
      send_byte(8'h3C, 1);
      cyc(0, 1, 0, 0, 1);
      probe(6);

      // test 6: reset while a word is pending
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 1, 0, 0, 0);
      send_byte(8'($urandom), 0);
      cyc(0, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      probe(7);

      // randomized traffic
      w_r = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(39) == 0) w_r = ~w_r;
         cyc(($urandom_range(699) == 0), w_r, ($urandom_range(3) != 0),
             1'($urandom), 1'($urandom));
      end

      // drain
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
      probe(8);
      @(negedge clk);
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
